// File: rtl/pgm_pkg.sv
// ----------------------------------------------------------------------------
// pgm_pkg : register map, FSM encoding and reset defaults for pgm_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pgm_pkg;

  localparam logic [7:0] ADDR_RATE_INC     = 8'h01;
  localparam logic [7:0] ADDR_PKT_COST     = 8'h02;
  localparam logic [7:0] ADDR_BUCKET_MAX   = 8'h03;
  localparam logic [7:0] ADDR_PKT_LIMIT    = 8'h04;
  localparam logic [7:0] ADDR_PROBE_PERIOD = 8'h05;

  localparam int RST_RATE_INC     = 1;
  localparam int RST_PKT_COST     = 64;
  localparam int RST_BUCKET_MAX   = 1024;
  localparam int RST_PKT_LIMIT    = 0;
  localparam int RST_PROBE_PERIOD = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_TOK = 3'd1,
    ST_REQ      = 3'd2,
    ST_BUSY     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pgm_token_bucket.sv
// ----------------------------------------------------------------------------
// pgm_token_bucket : saturating token accumulator with launch debit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pgm_token_bucket #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             debit,
  input  logic [CNT_W-1:0] rate_inc,
  input  logic [CNT_W-1:0] pkt_cost,
  input  logic [CNT_W-1:0] bucket_max,
  output logic             ge_cost
);

  logic [CNT_W-1:0] tokens;
  logic [CNT_W-1:0] tokens_nxt;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   net;

  // One extra bit keeps tokens + rate_inc exact before clamping to [0, bucket_max].
  always_comb begin
    sum = {1'b0, tokens} + {1'b0, rate_inc};
    net = sum;
    if (debit) begin
      net = (sum >= {1'b0, pkt_cost}) ? (sum - {1'b0, pkt_cost}) : '0;
    end
    if (net > {1'b0, bucket_max}) begin
      tokens_nxt = bucket_max;
    end else begin
      tokens_nxt = net[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens <= '0;
    end else if (clear) begin
      tokens <= '0;
    end else begin
      tokens <= tokens_nxt;
    end
  end

  assign ge_cost = (tokens >= pkt_cost);

endmodule

`default_nettype wire

// File: rtl/pgm_sched.sv
// ----------------------------------------------------------------------------
// pgm_sched : token-paced launch scheduler for the packet-generator reader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pgm_sched
  import pgm_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int PKT_CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [7:0]           cfg_addr,
  input  logic [CNT_W-1:0]     cfg_wdata,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic                 stop,
  output logic                 launch_req,
  output logic                 launch_probe,
  input  logic                 launch_ack,
  input  logic                 pkt_done,
  output logic                 busy,
  output logic                 finish,
  output logic [PKT_CNT_W-1:0] sent_pkt_cnt
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]     rate_inc;
  logic [CNT_W-1:0]     pkt_cost;
  logic [CNT_W-1:0]     bucket_max;
  logic [CNT_W-1:0]     pkt_limit;
  logic [CNT_W-1:0]     probe_period;
  logic [CNT_W-1:0]     probe_idx;
  logic [PKT_CNT_W-1:0] cnt_inc;

  logic ge_cost;
  logic ack_hit;
  logic is_probe;
  logic limit_hit;
  logic stop_pend;
  logic do_start;
  logic do_count;
  logic set_finish;
  logic latch_stop;

  assign ack_hit   = launch_ack & launch_req;
  assign busy      = (state == ST_WAIT_TOK) || (state == ST_REQ) || (state == ST_BUSY);
  assign cnt_inc   = sent_pkt_cnt + PKT_CNT_W'(1);
  assign limit_hit = (pkt_limit != '0) && (cnt_inc == PKT_CNT_W'(pkt_limit));
  assign is_probe  = (probe_period != '0) && (probe_idx == probe_period - CNT_W'(1));

  pgm_token_bucket #(
    .CNT_W (CNT_W)
  ) u_bucket (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (!busy),
    .debit      (ack_hit),
    .rate_inc   (rate_inc),
    .pkt_cost   (pkt_cost),
    .bucket_max (bucket_max),
    .ge_cost    (ge_cost)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_count   = 1'b0;
    set_finish = 1'b0;
    latch_stop = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_nxt = ST_WAIT_TOK;
          do_start  = 1'b1;
        end
      end
      ST_WAIT_TOK: begin
        if (stop) begin
          state_nxt  = ST_IDLE;
          set_finish = 1'b1;
        end else if (ge_cost) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack already committed the reader, so a coincident stop waits for pkt_done.
        if (ack_hit) begin
          state_nxt  = ST_BUSY;
          latch_stop = stop;
        end else if (stop) begin
          state_nxt  = ST_IDLE;
          set_finish = 1'b1;
        end
      end
      ST_BUSY: begin
        latch_stop = stop;
        if (pkt_done) begin
          do_count = 1'b1;
          if (stop_pend || stop || limit_hit) begin
            state_nxt  = ST_DONE;
            set_finish = 1'b1;
          end else begin
            state_nxt = ST_WAIT_TOK;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_req   <= 1'b0;
      launch_probe <= 1'b0;
      finish       <= 1'b0;
      stop_pend    <= 1'b0;
      sent_pkt_cnt <= '0;
      probe_idx    <= '0;
    end else begin
      launch_req   <= (state_nxt == ST_REQ);
      // Probe flag is captured on entry to REQ and frozen until the ack.
      launch_probe <= (state_nxt == ST_REQ) && ((state == ST_REQ) ? launch_probe : is_probe);
      if (do_start) begin
        finish       <= 1'b0;
        stop_pend    <= 1'b0;
        sent_pkt_cnt <= '0;
        probe_idx    <= '0;
      end else begin
        if (set_finish) finish    <= 1'b1;
        if (latch_stop) stop_pend <= 1'b1;
        if (do_count)   sent_pkt_cnt <= cnt_inc;
        if (ack_hit)    probe_idx <= launch_probe ? '0 : probe_idx + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_inc     <= CNT_W'(RST_RATE_INC);
      pkt_cost     <= CNT_W'(RST_PKT_COST);
      bucket_max   <= CNT_W'(RST_BUCKET_MAX);
      pkt_limit    <= CNT_W'(RST_PKT_LIMIT);
      probe_period <= CNT_W'(RST_PROBE_PERIOD);
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_wr) begin
        if (busy) begin
          cfg_err <= 1'b1;
        end else begin
          case (cfg_addr)
            ADDR_RATE_INC:     rate_inc <= cfg_wdata;
            ADDR_PKT_COST: begin
              if (cfg_wdata > bucket_max) cfg_err  <= 1'b1;
              else                        pkt_cost <= cfg_wdata;
            end
            ADDR_BUCKET_MAX: begin
              if (cfg_wdata < pkt_cost) cfg_err    <= 1'b1;
              else                      bucket_max <= cfg_wdata;
            end
            ADDR_PKT_LIMIT:    pkt_limit    <= cfg_wdata;
            ADDR_PROBE_PERIOD: probe_period <= cfg_wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pgm_sched.sv
// ----------------------------------------------------------------------------
// tb_pgm_sched : randomized self-checking bench for pgm_sched
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pgm_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_err;
  logic        start;
  logic        stop;
  logic        launch_req;
  logic        launch_probe;
  logic        launch_ack;
  logic        pkt_done;
  logic        busy;
  logic        finish;
  logic [63:0] sent_pkt_cnt;

  always #5 clk = ~clk;

  pgm_sched #(
    .CNT_W     (32),
    .PKT_CNT_W (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_err      (cfg_err),
    .start        (start),
    .stop         (stop),
    .launch_req   (launch_req),
    .launch_probe (launch_probe),
    .launch_ack   (launch_ack),
    .pkt_done     (pkt_done),
    .busy         (busy),
    .finish       (finish),
    .sent_pkt_cnt (sent_pkt_cnt)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: phase 0 = stopped, 1 = saving tokens, 2 = requesting, 3 = packet in flight
  int          m_phase;
  longint      m_tok, m_rate, m_cost, m_max, m_limit, m_period;
  logic [63:0] m_cnt;
  bit          m_fin, m_req, m_probe, m_stoppend, m_err;
  int          m_launch;

  task automatic model_reset();
    m_phase = 0; m_tok = 0; m_rate = 1; m_cost = 64; m_max = 1024; m_limit = 0; m_period = 0;
    m_cnt = '0; m_fin = 0; m_req = 0; m_probe = 0; m_stoppend = 0; m_err = 0; m_launch = 0;
  endtask

  task automatic model_step();
    longint t, w;
    int     ph;
    bit     hit, n_err;
    hit = launch_ack && m_req;
    ph  = m_phase;
    if (m_phase == 0) t = 0;
    else begin
      t = m_tok + m_rate - (hit ? m_cost : 0);
      if (t < 0) t = 0;
      if (t > m_max) t = m_max;
    end
    case (m_phase)
      0: if (start && !stop) begin
        ph = 1; m_cnt = '0; m_fin = 0; m_stoppend = 0; m_launch = 0;
      end
      1: if (stop) begin ph = 0; m_fin = 1; end
         else if (m_tok >= m_cost) begin
           ph = 2; m_launch++;
           m_probe = (m_period != 0) && ((m_launch % m_period) == 0);
         end
      2: if (hit) begin ph = 3; if (stop) m_stoppend = 1; end
         else if (stop) begin ph = 0; m_fin = 1; end
      3: begin
        if (stop) m_stoppend = 1;
        if (pkt_done) begin
          m_cnt = m_cnt + 1;
          if (m_stoppend || (m_limit != 0 && m_cnt == 64'(m_limit))) begin ph = 0; m_fin = 1; end
          else ph = 1;
        end
      end
      default: ph = 0;
    endcase
    n_err = 0;
    w = longint'(cfg_wdata);
    if (cfg_wr) begin
      if (m_phase != 0) n_err = 1;
      else case (cfg_addr)
        8'h01: m_rate = w;
        8'h02: if (w > m_max) n_err = 1; else m_cost = w;
        8'h03: if (w < m_cost) n_err = 1; else m_max = w;
        8'h04: m_limit = w;
        8'h05: m_period = w;
        default: ;
      endcase
    end
    m_phase = ph;
    m_tok   = t;
    m_req   = (ph == 2);
    if (!m_req) m_probe = 0;
    m_err   = n_err;
  endtask

  // Reader emulation and launch bookkeeping
  int          hold_knob = 0, done_knob = 2;
  int          r_wait = 0, r_done = -1;
  longint      lq[$];
  logic [63:0] pmask;
  longint      start_cyc;
  bit          prev_req = 0;

  function automatic int next_hold();
    return (hold_knob < 0) ? int'($urandom_range(0, 3)) : hold_knob;
  endfunction

  function automatic int next_done();
    return (done_knob < 0) ? int'($urandom_range(1, 4)) : done_knob;
  endfunction

  task automatic drive_reader(input bit noisy);
    launch_ack = 1'b0;
    pkt_done   = 1'b0;
    if (r_done == 0) begin pkt_done = 1'b1; r_done = -1; end
    else if (r_done > 0) r_done--;
    if (launch_req) begin
      if (r_wait <= 0) begin
        launch_ack = 1'b1;
        r_done     = next_done() - 1;
        r_wait     = next_hold();
      end else r_wait--;
    end else if (noisy && $urandom_range(0, 15) == 0) launch_ack = 1'b1;
    if (noisy && !pkt_done && r_done < 0 && !launch_req && $urandom_range(0, 15) == 0)
      pkt_done = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    start = 1'b0; stop = 1'b0; cfg_wr = 1'b0; launch_ack = 1'b0; pkt_done = 1'b0;
    check_val("launch_req", launch_req, m_req);
    if (m_req) check_val("launch_probe", launch_probe, m_probe);
    check_val("busy", busy, m_phase != 0);
    check_val("finish", finish, m_fin);
    check_val("sent_pkt_cnt", sent_pkt_cnt, m_cnt);
    check_val("cfg_err", cfg_err, m_err);
    if (launch_req && !prev_req) begin
      lq.push_back(cyc);
      if (launch_probe) pmask[lq.size()-1] = 1'b1;
    end
    prev_req = launch_req;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d, input bit exp_err);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    check_val("cfg_write_err", cfg_err, exp_err);
  endtask

  task automatic configure(input int rate, input int cost, input int mx, input int lim, input int per);
    cfg_write(8'h03, 32'hFFFF, 0);
    cfg_write(8'h02, cost, 0);
    cfg_write(8'h03, mx, 0);
    cfg_write(8'h01, rate, 0);
    cfg_write(8'h04, lim, 0);
    cfg_write(8'h05, per, 0);
  endtask

  task automatic do_start(input int first_hold);
    lq.delete(); pmask = '0;
    r_wait = first_hold; r_done = -1;
    start = 1'b1;
    start_cyc = cyc;
    tick();
  endtask

  task automatic run_to_end(input int budget, input bit noisy, input string tag);
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      drive_reader(noisy);
      if (noisy) begin
        if ($urandom_range(0, 99) == 0) stop = 1'b1;
        if ($urandom_range(0, 49) == 0) begin
          cfg_wr = 1'b1; cfg_addr = 8'($urandom_range(0, 7)); cfg_wdata = $urandom;
        end
      end
      tick();
      n++;
    end
    check_val({tag, "_ended"}, busy, 0);
    check_val({tag, "_finish"}, finish, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rate, cost, mx, lim, per, n;
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0; launch_ack = 1'b0; pkt_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_launch_req", launch_req, 0);
    check_val("rst_launch_probe", launch_probe, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_finish", finish, 0);
    check_val("rst_cnt", sent_pkt_cnt, 0);
    check_val("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic pacing and limit
    configure(1, 4, 16, 3, 0);
    hold_knob = 0; done_knob = 2;
    do_start(0);
    run_to_end(300, 0, "t1");
    check_val("t1_latency", (lq.size() > 0) ? lq[0] - start_cyc : -1, 6);
    check_val("t1_launches", lq.size(), 3);
    check_val("t1_cnt", sent_pkt_cnt, 3);

    // Probe marking
    configure(1, 4, 16, 7, 3);
    do_start(0);
    run_to_end(400, 0, "t2");
    check_val("t2_launches", lq.size(), 7);
    check_val("t2_probe_mask", pmask, 64'b0100100);

    // Rejected cost keeps the old one
    cfg_write(8'h03, 8, 0);
    cfg_write(8'h01, 2, 0);
    cfg_write(8'h02, 10, 1);
    cfg_write(8'h04, 1, 0);
    cfg_write(8'h05, 0, 0);
    do_start(0);
    run_to_end(100, 0, "t3");
    check_val("t3_latency", (lq.size() > 0) ? lq[0] - start_cyc : -1, 4);

    // Long ack stall: saturation and debit on the ack cycle
    configure(1, 8, 8, 2, 1);
    do_start(20);
    run_to_end(300, 0, "t4");
    check_val("t4_first", (lq.size() > 0) ? lq[0] - start_cyc : -1, 10);
    check_val("t4_second", (lq.size() > 1) ? lq[1] - start_cyc : -1, 39);
    check_val("t4_probe_mask", pmask, 64'b11);

    // Stop and config write while a packet is in flight
    configure(1, 4, 16, 0, 0);
    done_knob = 5;
    do_start(0);
    n = 0;
    while (!(launch_req && r_wait <= 0) && n < 50) begin drive_reader(0); tick(); n++; end
    drive_reader(0);
    tick();
    check_val("t5_in_flight", busy, 1);
    stop = 1'b1; cfg_wr = 1'b1; cfg_addr = 8'h01; cfg_wdata = 32'd7;
    drive_reader(0);
    tick();
    check_val("t5_cfg_err", cfg_err, 1);
    run_to_end(100, 0, "t5");
    check_val("t5_launches", lq.size(), 1);
    check_val("t5_cnt", sent_pkt_cnt, 1);

    // Randomized runs
    hold_knob = -1; done_knob = -1;
    for (int run = 0; run < 30; run++) begin
      rate = $urandom_range(1, 5);
      cost = $urandom_range(1, 24);
      mx   = $urandom_range(cost, 48);
      lim  = $urandom_range(1, 5);
      per  = $urandom_range(0, 4);
      configure(rate, cost, mx, lim, per);
      if ($urandom_range(0, 2) == 0) cfg_write(8'h02, mx + 1 + $urandom_range(0, 9), 1);
      if ($urandom_range(0, 4) == 0) begin start = 1'b1; stop = 1'b1; tick(); end
      do_start(next_hold());
      run_to_end(800, 1, "rnd");
    end

    // Asynchronous reset during a request, then defaults restored
    configure(1, 4, 16, 0, 0);
    hold_knob = 1000; done_knob = 2;
    do_start(1000);
    n = 0;
    while (!launch_req && n < 50) begin drive_reader(0); tick(); n++; end
    check_val("t6_req_up", launch_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_req", launch_req, 0);
    check_val("t6_async_probe", launch_probe, 0);
    model_reset();
    @(negedge clk);
    check_val("t6_busy", busy, 0);
    check_val("t6_cnt", sent_pkt_cnt, 0);
    rst_n = 1'b1;
    tick();
    do_start(1000);
    n = 0;
    while (lq.size() == 0 && n < 200) begin drive_reader(0); tick(); n++; end
    check_val("t6_default_latency", (lq.size() > 0) ? lq[0] - start_cyc : -1, 66);
    stop = 1'b1;
    drive_reader(0);
    tick();
    check_val("t6_stop_finish", finish, 1);
    check_val("t6_stop_req", launch_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
